pulse_width_classifier: RTL and testbench
=========================================

// Module: pulse_width_classifier
// PURPOSE
//   Multi-channel pulse-width classifier for asynchronous level inputs.
//   Per channel: 2-FF synchroniser, high-time counter, falling-edge classification
//   against runtime thresholds (SHORT/OK/LONG), and a valid/ready event register.
//   Sits between raw external inputs and the control logic that consumes events.
// PARAMETERS
//   CHANNELS  4   number of independent input channels
//   CNT_W     8   width counter bits; counter saturates at 2^CNT_W-1
//   DEGLITCH  2   filter length in cycles; used only with PWC_DEGLITCH_EN
// PORTS
//   clk          in   1             clock, all logic on rising edge
//   rst          in   1             synchronous reset, active-high
//   in           in   CHANNELS      async level inputs
//   thr_lo       in   CNT_W         min OK width (inclusive), shared by all channels
//   thr_hi       in   CNT_W         max OK width (inclusive), shared by all channels
//   mode         in   1             0: report OK only; 1: report every pulse
//   evt_valid    out  CHANNELS      event pending, per channel
//   evt_ready    in   CHANNELS      consumer accepts event, per channel
//   evt_class    out  2*CHANNELS    ch i at [2i+1:2i]: 00 SHORT, 01 OK, 10 LONG
//   evt_width    out  CNT_W*CHANNELS  ch i at [CNT_W*i +: CNT_W]: measured width
//   overrun      out  CHANNELS      sticky: event dropped because register was full
//   clr_overrun  in   CHANNELS      clears overrun, per channel
// BEHAVIOUR
// - Reset (sync, active-high): sync FFs, prev level, counters, evt_valid, evt_class,
//   evt_width, overrun all 0. Takes effect at the next edge with rst=1, mid-pulse too.
// - Sync: s1<=in, s2<=s1; lvl=s2 (filtered level with PWC_DEGLITCH_EN); p<=lvl.
// - Rise (lvl & ~p): cnt<=1. High (lvl & p): cnt<=cnt+1, saturates at 2^CNT_W-1.
// - Width = number of consecutive high samples of lvl.
//   Without filter this equals the count of clk edges that sampled in high.
// - Fall (~lvl & p): classify cnt using thr_lo/thr_hi sampled that same cycle.
//   cnt<thr_lo -> SHORT; else cnt>thr_hi -> LONG; else OK.
//   Saturated cnt -> LONG unless thr_hi = max. thr_lo>thr_hi -> never OK.
// - Report filter: mode=0 drops SHORT/LONG silently (no overrun); mode=1 reports all.
// - Latency: evt_valid rises after the 3rd clk edge following the first low
//   sample of in.
// - Handshake: transfer when evt_valid & evt_ready. evt_valid, class and width
//   hold stable until transfer.
//   New event + register empty, or + transfer same cycle -> load; valid stays 1.
//   New event + valid & ~ready -> new event dropped, old kept, overrun<=1.
//   Overrun set and clr_overrun in the same cycle -> set wins.
// - Channels fully independent; simultaneous events on any channels all captured.
// - Reset mid-pulse: restarts from 0. With in still high, a rise is seen after
//   sync, so the reported width is partial.
// CONFIGURATION
// - PWC_DEGLITCH_EN defined: per-channel filter between s2 and lvl.
//   lvl toggles only after s2 differs from lvl for DEGLITCH consecutive cycles.
//   Both edges are delayed by DEGLITCH, so width is preserved.
//   Pulses/gaps shorter than DEGLITCH cycles are removed; latency grows by DEGLITCH.
// - PWC_DEGLITCH_EN undefined: lvl=s2; DEGLITCH is ignored; no filter logic.
// TESTING (CHANNELS=4, CNT_W=8, thr_lo=15, thr_hi=30, evt_ready=1 unless stated)
// - in[0] high 20 cycles, mode=0 -> evt_valid[0] 1 cycle, 3 edges after fall;
//   class 01, width 20.
// - in[1] high 10 cycles: mode=0 -> no event, overrun 0;
//   mode=1 -> class 00, width 10.
// - in[2] high 300 cycles, mode=1 -> class 10, width 255.
//   Pulse of exactly 15 and exactly 30 -> class 01.
// - evt_ready[0]=0, two OK pulses (20, then 25) -> width 20 held, overrun[0]=1.
//   Then ready=1 -> transfer, valid 0. clr_overrun[0] -> overrun[0]=0.
// - in[0] and in[3] high 20 cycles, same cycles -> both valid same cycle;
//   rst=1 mid-pulse -> all outputs 0 next cycle.
// - PWC_DEGLITCH_EN, DEGLITCH=2: 1-cycle in pulse -> no event.
//   20-cycle pulse -> width 20, evt_valid 2 cycles later than unfiltered.

Source files
------------

// File: rtl/pulse_width_classifier.sv
// pulse_width_classifier: per-channel synchroniser, high-time counter,
// falling-edge SHORT/OK/LONG classification and valid/ready event register.
// Optional build macro PWC_DEGLITCH_EN adds a DEGLITCH-cycle level filter
// between the synchroniser and the edge detector.
module pulse_width_classifier #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEGLITCH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in,
  input  logic [CNT_W-1:0]          thr_lo,
  input  logic [CNT_W-1:0]          thr_hi,
  input  logic                      mode,
  output logic [CHANNELS-1:0]       evt_valid,
  input  logic [CHANNELS-1:0]       evt_ready,
  output logic [2*CHANNELS-1:0]     evt_class,
  output logic [CNT_W*CHANNELS-1:0] evt_width,
  output logic [CHANNELS-1:0]       overrun,
  input  logic [CHANNELS-1:0]       clr_overrun
);

  typedef enum logic [1:0] {
    CLS_SHORT = 2'b00,
    CLS_OK    = 2'b01,
    CLS_LONG  = 2'b10
  } pwc_class_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] lvl;
  logic [CHANNELS-1:0] p;
  logic [CNT_W-1:0]    cnt      [CHANNELS];
  pwc_class_e          cls      [CHANNELS];
  pwc_class_e          class_r  [CHANNELS];
  logic [CNT_W-1:0]    width_r  [CHANNELS];
  logic [CHANNELS-1:0] new_evt;
  logic [CHANNELS-1:0] take;

`ifdef PWC_DEGLITCH_EN
  localparam int unsigned DG_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

  logic [DG_W-1:0]     dg_cnt [CHANNELS];
  logic [CHANNELS-1:0] lvl_q;

  // Level follows s2 only after s2 has disagreed for DEGLITCH consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) dg_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (s2[i] != lvl_q[i]) begin
          if (dg_cnt[i] == DG_W'(DEGLITCH - 1)) begin
            lvl_q[i]  <= s2[i];
            dg_cnt[i] <= '0;
          end else begin
            dg_cnt[i] <= dg_cnt[i] + 1'b1;
          end
        end else begin
          dg_cnt[i] <= '0;
        end
      end
    end
  end

  assign lvl = lvl_q;
`else
  // Unfiltered build: the synchroniser output is the level; DEGLITCH has no effect.
  if (DEGLITCH > 0) begin : g_direct
    assign lvl = s2;
  end else begin : g_direct_zero
    assign lvl = s2;
  end
`endif

  // Classify the running count on a falling level and decide whether it is reported.
  always_comb begin
    new_evt = '0;
    take    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cls[i] = CLS_OK;
      if (cnt[i] < thr_lo) begin
        cls[i] = CLS_SHORT;
      end else if (cnt[i] > thr_hi) begin
        cls[i] = CLS_LONG;
      end
      new_evt[i] = ~lvl[i] & p[i] & (mode | (cls[i] == CLS_OK));
      take[i]    = ~evt_valid[i] | evt_ready[i];
    end
  end

  // Synchroniser, width counter, event register and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      p         <= '0;
      evt_valid <= '0;
      overrun   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt[i]     <= '0;
        class_r[i] <= CLS_SHORT;
        width_r[i] <= '0;
      end
    end else begin
      s1 <= in;
      s2 <= s1;
      p  <= lvl;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (lvl[i] & ~p[i]) begin
          cnt[i] <= CNT_W'(1);
        end else if (lvl[i] & p[i] & (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end

        // A reported event loads whenever the slot is empty or being drained now.
        if (new_evt[i] & take[i]) begin
          evt_valid[i] <= 1'b1;
          class_r[i]   <= cls[i];
          width_r[i]   <= cnt[i];
        end else if (evt_valid[i] & evt_ready[i]) begin
          evt_valid[i] <= 1'b0;
        end

        if (new_evt[i] & ~take[i]) begin
          overrun[i] <= 1'b1;
        end else if (clr_overrun[i]) begin
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten per-channel event fields onto the output buses.
  always_comb begin
    evt_class = '0;
    evt_width = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      evt_class[2*i +: 2]         = class_r[i];
      evt_width[CNT_W*i +: CNT_W] = width_r[i];
    end
  end

endmodule

// File: tb/tb_pulse_width_classifier.sv
// Self-checking bench for pulse_width_classifier (default build).
// Directed pulses followed by randomized traffic, compared every cycle
// against a pulse-level reference model.
module tb_pulse_width_classifier;

  localparam int CH = 4;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] din;
  logic [W-1:0]  thr_lo;
  logic [W-1:0]  thr_hi;
  logic          mode;
  logic [CH-1:0] evt_valid;
  logic [CH-1:0] evt_ready;
  logic [2*CH-1:0] evt_class;
  logic [W*CH-1:0] evt_width;
  logic [CH-1:0] overrun;
  logic [CH-1:0] clr_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: run lengths of high input samples, a two-edge delay
  // to the event register, and the event register itself.
  int            run   [CH];
  bit            st1_v [CH];
  bit            st2_v [CH];
  int            st1_w [CH];
  int            st2_w [CH];
  logic [CH-1:0] m_valid;
  logic [CH-1:0] m_ovr;
  logic [1:0]    m_cls [CH];
  logic [W-1:0]  m_w   [CH];

  pulse_width_classifier #(
    .CHANNELS(CH),
    .CNT_W   (W),
    .DEGLITCH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .thr_lo     (thr_lo),
    .thr_hi     (thr_hi),
    .mode       (mode),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_class  (evt_class),
    .evt_width  (evt_width),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] classify(input int w, input int lo, input int hi);
    if (w < lo) return 2'b00;
    if (w > hi) return 2'b10;
    return 2'b01;
  endfunction

  task automatic model_edge();
    bit         rep;
    bit         drop;
    logic [1:0] c;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        run[i] = 0; st1_v[i] = 0; st2_v[i] = 0; st1_w[i] = 0; st2_w[i] = 0;
        m_cls[i] = 2'b00; m_w[i] = '0;
      end
      m_valid = '0;
      m_ovr   = '0;
      return;
    end
    for (int i = 0; i < CH; i++) begin
      rep  = 0;
      drop = 0;
      c    = 2'b00;
      if (st2_v[i]) begin
        c   = classify(st2_w[i], int'(thr_lo), int'(thr_hi));
        rep = mode || (c == 2'b01);
      end
      if (rep) begin
        if (!m_valid[i] || evt_ready[i]) begin
          m_valid[i] = 1'b1;
          m_cls[i]   = c;
          m_w[i]     = W'(st2_w[i]);
        end else begin
          drop = 1;
        end
      end else if (m_valid[i] && evt_ready[i]) begin
        m_valid[i] = 1'b0;
      end
      if (drop) m_ovr[i] = 1'b1;
      else if (clr_overrun[i]) m_ovr[i] = 1'b0;
      st2_v[i] = st1_v[i];
      st2_w[i] = st1_w[i];
      if (din[i]) begin
        run[i]++;
        st1_v[i] = 0;
      end else begin
        st1_v[i] = (run[i] > 0);
        st1_w[i] = (run[i] > 255) ? 255 : run[i];
        run[i]   = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [2*CH-1:0] cp;
    logic [W*CH-1:0] wp;
    for (int i = 0; i < CH; i++) begin
      cp[2*i +: 2] = m_cls[i];
      wp[W*i +: W] = m_w[i];
    end
    chk("model_valid", 64'(evt_valid), 64'(m_valid));
    chk("model_class", 64'(evt_class), 64'(cp));
    chk("model_width", 64'(evt_width), 64'(wp));
    chk("model_overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic pulse(input logic [CH-1:0] mask, input int len);
    din = din | mask;
    repeat (len) step();
    din = din & ~mask;
  endtask

  int rem [CH];

  initial begin
    rst = 1'b1; din = '0; thr_lo = 8'd15; thr_hi = 8'd30; mode = 1'b0;
    evt_ready = '1; clr_overrun = '0;
    step(); step();
    chk("rst_valid", 64'(evt_valid), 64'h0);
    chk("rst_class", 64'(evt_class), 64'h0);
    chk("rst_width", 64'(evt_width), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    rst = 1'b0;
    repeat (3) step();

    // OK pulse on ch0: valid exactly on the third edge after the fall, for one cycle.
    pulse(4'b0001, 20);
    step(); step();
    chk("lat_early", 64'(evt_valid[0]), 64'h0);
    step();
    chk("lat_valid", 64'(evt_valid[0]), 64'h1);
    chk("ok20_class", 64'(evt_class[1:0]), 64'h1);
    chk("ok20_width", 64'(evt_width[7:0]), 64'd20);
    step();
    chk("one_cycle", 64'(evt_valid[0]), 64'h0);

    // Short pulse: dropped in mode 0, reported in mode 1.
    pulse(4'b0010, 10);
    repeat (3) step();
    chk("short_m0_valid", 64'(evt_valid[1]), 64'h0);
    chk("short_m0_ovr", 64'(overrun[1]), 64'h0);
    mode = 1'b1;
    pulse(4'b0010, 10);
    repeat (3) step();
    chk("short_m1_valid", 64'(evt_valid[1]), 64'h1);
    chk("short_m1_class", 64'(evt_class[3:2]), 64'h0);
    chk("short_m1_width", 64'(evt_width[15:8]), 64'd10);

    // Long pulse saturates.
    pulse(4'b0100, 300);
    repeat (3) step();
    chk("long_valid", 64'(evt_valid[2]), 64'h1);
    chk("long_class", 64'(evt_class[5:4]), 64'h2);
    chk("long_width", 64'(evt_width[23:16]), 64'd255);

    // Inclusive threshold boundaries.
    mode = 1'b0;
    pulse(4'b0001, 15);
    repeat (3) step();
    chk("bnd15_class", 64'(evt_class[1:0]), 64'h1);
    chk("bnd15_width", 64'(evt_width[7:0]), 64'd15);
    pulse(4'b0001, 30);
    repeat (3) step();
    chk("bnd30_class", 64'(evt_class[1:0]), 64'h1);
    chk("bnd30_width", 64'(evt_width[7:0]), 64'd30);
    repeat (2) step();

    // Back-pressure: second event dropped, overrun set, then drain and clear.
    evt_ready = 4'b1110;
    pulse(4'b0001, 20);
    repeat (3) step();
    repeat (2) step();
    pulse(4'b0001, 25);
    repeat (3) step();
    chk("bp_valid", 64'(evt_valid[0]), 64'h1);
    chk("bp_width", 64'(evt_width[7:0]), 64'd20);
    chk("bp_overrun", 64'(overrun[0]), 64'h1);
    evt_ready = '1;
    step();
    chk("bp_drained", 64'(evt_valid[0]), 64'h0);
    chk("bp_ovr_sticky", 64'(overrun[0]), 64'h1);
    clr_overrun = 4'b0001;
    step();
    clr_overrun = '0;
    chk("bp_ovr_clr", 64'(overrun[0]), 64'h0);

    // Simultaneous channels, then reset in the middle of a pulse.
    evt_ready = '0;
    pulse(4'b1001, 20);
    repeat (3) step();
    chk("simul_valid", 64'({evt_valid[3], evt_valid[0]}), 64'h3);
    din = 4'b1001;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 64'(evt_valid), 64'h0);
    chk("midrst_class", 64'(evt_class), 64'h0);
    chk("midrst_width", 64'(evt_width), 64'h0);
    chk("midrst_overrun", 64'(overrun), 64'h0);
    evt_ready = '1;
    mode = 1'b1;
    repeat (5) step();
    din = '0;
    repeat (3) step();
    chk("partial_valid", 64'({evt_valid[3], evt_valid[0]}), 64'h3);
    chk("partial_w0", 64'(evt_width[7:0]), 64'd5);
    chk("partial_w3", 64'(evt_width[31:24]), 64'd5);
    chk("partial_cls0", 64'(evt_class[1:0]), 64'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < CH; i++) rem[i] = $urandom_range(1, 40);
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if (rem[i] == 0) begin
          din[i] = ~din[i];
          rem[i] = ($urandom_range(0, 19) == 0) ? $urandom_range(256, 300)
                                                : $urandom_range(1, 40);
        end else begin
          rem[i]--;
        end
        evt_ready[i]   = ($urandom_range(0, 3) != 0);
        clr_overrun[i] = ($urandom_range(0, 9) == 0);
      end
      if (n % 150 == 0) begin
        thr_lo = W'($urandom_range(0, 40));
        thr_hi = W'($urandom_range(0, 45));
        mode   = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
